// File: rtl/adc_bram_readout.sv
// adc_bram_readout: reads a captured frame from the BRAM read port and streams it as AXI4-Stream beats.
// Optional per-frame header beat when ADC_READOUT_HEADER_EN is defined.
module adc_bram_readout #(
  parameter int DWIDTH       = 256,
  parameter int MAX_XFER     = 2048,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           bram_addr,
  output logic                  bram_en,
  output logic [DWIDTH/8-1:0]   bram_we,
  output logic [DWIDTH-1:0]     bram_wdata,
  input  logic [DWIDTH-1:0]     bram_rdata,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);
  localparam int ADDR_BITS = $clog2(MAX_XFER);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = PW + 1;
  localparam int SH        = $clog2(DWIDTH / 8);
`ifdef ADC_READOUT_HEADER_EN
  localparam int LAST = MAX_XFER;
`else
  localparam int LAST = MAX_XFER - 1;
`endif
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [31:0]             bram_addr_q, bram_addr_d;
  logic                    en_q, en_d;
  logic [READ_LATENCY-1:0] sr_q, sr_d;
  logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]           cnt_q, cnt_d, infl;
  logic [ADDR_BITS:0]      beat_q, beat_d;
  logic                    done_q, done_d;
  logic [DWIDTH-1:0]       mem_q [FIFO_DEPTH];
  logic [DWIDTH-1:0]       push_data;
  logic                    push, pop, issue, start;

  assign bram_clk      = aclk;
  assign bram_rst      = areset;
  assign bram_we       = '0;
  assign bram_wdata    = '0;
  assign bram_en       = en_q;
  assign bram_addr     = bram_addr_q;
  assign busy_o        = state_q != IDLE;
  assign done_o        = done_q;
  assign start         = state_q == IDLE && start_i;
  assign m_axis_tvalid = cnt_q != '0;
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rp_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid && beat_q == (ADDR_BITS+1)'(LAST);
  assign pop           = m_axis_tvalid && m_axis_tready;

`ifdef ADC_READOUT_HEADER_EN
  logic [31:0]       frame_q, frame_d;
  logic [DWIDTH-1:0] hdr;
  always_comb begin
    hdr = '0;
    hdr[DWIDTH-1 -: 96] = {32'(MAX_XFER), frame_q, 32'hADC0_CAFE};
    frame_d = frame_q + 32'(done_d);
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) frame_q <= '0;
    else        frame_q <= frame_d;
  // Header enters the FIFO on the start edge; nothing can be in flight then.
  assign push      = start || sr_q[READ_LATENCY-1];
  assign push_data = start ? hdr : bram_rdata;
`else
  assign push      = sr_q[READ_LATENCY-1];
  assign push_data = bram_rdata;
`endif

  always_comb begin
    infl = CW'(en_q);
    for (int i = 0; i < READ_LATENCY; i++) infl = infl + CW'(sr_q[i]);
    // Credit covers everything already queued or still coming back from the BRAM.
    issue       = state_q == READ && ({1'b0, cnt_q} + {1'b0, infl}) < (CW+1)'(FIFO_DEPTH);
    state_d     = state_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    en_d        = issue;
    bram_addr_d = issue ? 32'(addr_q) << SH : bram_addr_q;
    sr_d        = READ_LATENCY'({sr_q, en_q});
    wp_d        = wp_q + PW'(push);
    rp_d        = rp_q + PW'(pop);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    beat_d      = pop ? beat_q + 1'b1 : beat_q;
    if (start) begin
      state_d = READ;
      addr_d  = '0;
      beat_d  = '0;
    end
    if (issue) begin
      addr_d = addr_q + 1'b1;
      if (addr_q == ADDR_BITS'(MAX_XFER - 1)) state_d = DRAIN;
    end
    if (state_q == DRAIN && pop && m_axis_tlast && cnt_q == CW'(1) && infl == '0) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      bram_addr_q <= '0;
      en_q        <= 1'b0;
      sr_q        <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      bram_addr_q <= bram_addr_d;
      en_q        <= en_d;
      sr_q        <= sr_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
    end

  always_ff @(posedge aclk)
    if (push) mem_q[wp_q] <= push_data;
endmodule

// File: tb/tb_adc_bram_readout.sv
// tb_adc_bram_readout: table-driven frame scenarios plus hand-written reset and latency sequences.
module tb_adc_bram_readout;
  localparam int DW = 256, MX = 16, RL = 2, FD = 8;
`ifdef ADC_READOUT_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif
  logic            aclk = 0, areset = 1, start_i = 0, m_axis_tready = 0;
  logic            busy_o, done_o, bram_en, bram_clk, bram_rst, m_axis_tvalid, m_axis_tlast;
  logic [31:0]     bram_addr;
  logic [DW/8-1:0] bram_we;
  logic [DW-1:0]   bram_wdata, bram_rdata, m_axis_tdata, p1, p2;
  int checks = 0, errors = 0, frame_no = 0;

  typedef struct {
    int pct;
    int hold;
    bit poke;
    int exp_en;
    int exp_dat;
    int exp_done;
  } vec_t;
  vec_t vt[6];

  adc_bram_readout #(.DWIDTH(DW), .MAX_XFER(MX), .READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .aclk(aclk), .areset(areset), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .bram_clk(bram_clk), .bram_rst(bram_rst),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  // Two-clock BRAM model: word i holds value i; idle cycles return a poison pattern.
  always @(posedge aclk) begin
    p1 <= bram_en ? DW'(bram_addr >> 5) : {8{32'hDEAD_BEEF}};
    p2 <= p1;
  end
  assign bram_rdata = p2;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input vec_t v, input int k);
    return k >= v.hold && $urandom_range(99) < v.pct;
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    int k = 0, beats = 0, issued = 0, first_en = -1, first_dat = -1, occ_bad = 0, bad = 0;
    bit fin = 0, pv = 0, pr = 0, pl = 0;
    logic [DW-1:0] pd = '0, h = '0, exp;
    string nm = $sformatf("f%0d", id);
    h[DW-1 -: 96] = {32'(MX), 32'(frame_no), 32'hADC0_CAFE};
    @(posedge aclk); #1 start_i = 1;
    @(posedge aclk); #1 start_i = 0;
    m_axis_tready = rdy(v, 0);
    while (!fin) begin
      @(negedge aclk);
      if (k == 0) chk({nm, " busy_rise"}, busy_o, 1);
      if (bram_en) begin
        if (first_en < 0) first_en = k;
        chk({nm, " addr"}, bram_addr, 32'(issued) << 5);
        issued++;
      end
      if (issued + HB - beats > FD) occ_bad++;
      if (pv && !pr) begin
        chk({nm, " stall_ctl"}, {m_axis_tvalid, m_axis_tlast}, {1'b1, pl});
        chk({nm, " stall_data"}, m_axis_tdata, pd);
      end
      if (m_axis_tvalid && first_dat < 0 && beats == HB) first_dat = k;
      if (m_axis_tvalid && m_axis_tready) begin
        exp = (HB == 1 && beats == 0) ? h : DW'(beats - HB);
        chk({nm, " data"}, m_axis_tdata, exp);
        chk({nm, " tlast"}, m_axis_tlast, beats == HB + MX - 1);
        beats++;
      end
      pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
      if (v.hold > 0 && k == v.hold) chk({nm, " credit_hold"}, issued <= FD - HB, 1);
      if (done_o) begin
        fin = 1;
        chk({nm, " beats"}, beats, HB + MX);
        chk({nm, " busy_fall"}, busy_o, 0);
        if (v.exp_done >= 0) chk({nm, " done_cycle"}, k, v.exp_done);
      end else if (k >= 3000) begin
        fin = 1;
        chk({nm, " done_timeout"}, done_o, 1);
      end else begin
        @(posedge aclk); #1;
        k++;
        start_i = v.poke && (k == 5 || k == 17 || k == 19);
        m_axis_tready = rdy(v, k);
      end
    end
    start_i = 0;
    chk({nm, " first_en"}, first_en, v.exp_en);
    if (v.exp_dat >= 0) chk({nm, " first_valid"}, first_dat, v.exp_dat);
    chk({nm, " occupancy"}, occ_bad, 0);
    frame_no++;
    @(negedge aclk);
    chk({nm, " done_pulse"}, done_o, 0);
    repeat (6) begin
      @(negedge aclk);
      if (busy_o || bram_en || m_axis_tvalid) bad++;
    end
    chk({nm, " idle_after"}, bad, 0);
  endtask

  initial begin
    int k, bad;
    vt[0] = '{pct: 100, hold: 0,  poke: 0, exp_en: 1, exp_dat: 4,  exp_done: 20};
    vt[1] = '{pct: 30,  hold: 0,  poke: 0, exp_en: 1, exp_dat: -1, exp_done: -1};
    vt[2] = '{pct: 100, hold: 50, poke: 0, exp_en: 1, exp_dat: -1, exp_done: -1};
    vt[3] = '{pct: 100, hold: 0,  poke: 1, exp_en: 1, exp_dat: 4,  exp_done: 20};
    vt[4] = '{pct: 100, hold: 0,  poke: 0, exp_en: 1, exp_dat: 4,  exp_done: 20};
    vt[5] = '{pct: 50,  hold: 10, poke: 0, exp_en: 1, exp_dat: -1, exp_done: -1};
    #12;
    chk("reset_ctl", {busy_o, done_o, bram_en, m_axis_tvalid, m_axis_tlast}, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_addr", bram_addr, 0);
    chk("tie_we", bram_we, 0);
    chk("tie_wdata", bram_wdata, 0);
    chk("bram_rst", bram_rst, 1);
    @(posedge aclk); #1 areset = 0;
    chk("bram_clk", bram_clk, aclk);
    for (int i = 0; i < 6; i++) run_frame(i, vt[i]);
    @(posedge aclk); #1 start_i = 1;
    @(posedge aclk); #1 start_i = 0; m_axis_tready = 1;
    k = 0;
    do begin @(negedge aclk); k++; end
    while (!(m_axis_tvalid && m_axis_tdata == DW'(5)) && k < 100);
    chk("rst_reach_beat5", m_axis_tdata, DW'(5));
    #1 areset = 1; #1;
    chk("rst_mid_ctl", {busy_o, done_o, bram_en, m_axis_tvalid, m_axis_tlast}, 0);
    chk("rst_mid_tdata", m_axis_tdata, 0);
    chk("rst_mid_addr", bram_addr, 0);
    @(posedge aclk); @(posedge aclk); #1 areset = 0;
    frame_no = 0;
    bad = 0;
    repeat (5) begin
      @(negedge aclk);
      if (done_o || busy_o || m_axis_tvalid) bad++;
    end
    chk("rst_no_done", bad, 0);
    run_frame(6, vt[0]);
    run_frame(7, vt[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
